uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//   UART receiver that consumes the baud_clk oversampling clock from baud_rate_generator.
//   Synchronises the serial rx line and locates the start bit by oversampling. Samples each
//   bit at mid-period, then deframes LSB-first data with optional parity.
//   Hands each received byte downstream on a valid/ready interface.
// PARAMETERS
//   DATA_BITS   8   data bits per frame (5..9)
//   OVERSAMPLE  16  baud_clk rising edges per bit period (even, >=4)
//   PARITY_EN   0   1 = one parity bit follows data
//   PARITY_ODD  0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
// PORTS
//   clk         in   1          system clock
//   reset_n     in   1          async active-low reset
//   baud_clk    in   1          oversample clock (clk domain, level); each 0->1 = one tick
//   rx          in   1          serial line, idle high, asynchronous
//   rx_data     out  DATA_BITS  received word, LSB = first data bit
//   rx_valid    out  1          rx_data/flags valid; held until accepted
//   rx_ready    in   1          downstream accepts when rx_valid & rx_ready
//   frame_err   out  1          stop bit sampled 0 (qualified by rx_valid)
//   parity_err  out  1          parity mismatch (qualified by rx_valid; 0 if PARITY_EN=0)
//   overrun     out  1          1-clk pulse: frame completed while rx_valid still held
//   busy        out  1          1 whenever FSM not in IDLE
// BEHAVIOUR
//   Reset: state IDLE, counters 0, rx sync flops = 1, rx_data 0, all flags/valid/busy 0.
//   rx passes through 2 flops (rx_s). tick = baud_clk & ~baud_prev (baud_prev: 1 flop, reset 0).
//   All FSM actions occur only on clk edges where tick=1. Counter width = clog2(OVERSAMPLE).
//   IDLE:   tick & rx_s==0 -> START, cnt<=0.
//   START:  cnt counts ticks; at cnt==OVERSAMPLE/2-1 sample rx_s:
//           1 -> false start, back to IDLE, nothing output; 0 -> DATA, cnt<=0, bit_idx<=0.
//   DATA:   at cnt==OVERSAMPLE-1 shift rx_s in (LSB first), cnt<=0, bit_idx++;
//           after bit DATA_BITS-1 -> PARITY if PARITY_EN else STOP.
//   PARITY: at cnt==OVERSAMPLE-1 capture bit; err = (^data ^ bit) != PARITY_ODD -> STOP.
//   STOP:   at cnt==OVERSAMPLE-1 sample stop bit; complete frame; -> IDLE same edge.
//   Completion (same clk edge as stop sample): if rx_valid==0 or accepted this cycle, load
//     rx_data, frame_err=~rx_s, parity_err, rx_valid<=1.
//     Otherwise drop new frame, keep old data/flags, pulse overrun for 1 clk.
//   Accept: rx_valid & rx_ready -> rx_valid<=0 next edge; simultaneous accept+completion:
//     new frame loads, rx_valid stays 1, no overrun.
//   Framing-error frames are still delivered (frame_err=1). FSM does not wait for line idle.
//     If rx stays 0 (break), IDLE re-enters START on the next tick.
//   Latency: rx_valid high on the clk after the edge carrying the stop-sample tick.
//   rx_ready ignored while rx_valid=0. reset_n low mid-frame aborts instantly to reset values.
// TESTING
//   (Bench: baud_clk toggles every 4 clk; bit = OVERSAMPLE ticks.)
//   1 Reset: reset_n=0 with rx=0, baud active -> rx_valid/busy/flags/overrun stay 0.
//     Release -> IDLE.
//   2 8N1 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5, frame_err=0.
//     Held until rx_ready pulses 1 clk -> rx_valid=0 next clk.
//   3 rx low for 4 ticks then high -> no rx_valid, busy returns 0 by tick 8.
//     Next valid frame 0x5A is received.
//   4 Frame 0x3C with stop bit 0 -> rx_valid=1, rx_data=0x3C, frame_err=1.
//   5 0x11 then 0x22 back-to-back, rx_ready=0 -> one overrun pulse; rx_data stays 0x11.
//     Repeat with rx_ready=1 on completion clk -> 0x22 loads, no overrun.
//   6 PARITY_EN=1 even, data 0x07 with parity bit 0 -> parity_err=1.
//     Parity bit 1 -> parity_err=0. Assert reset_n mid-data -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by an oversampling tick (baud_clk rising edges).
// Two-flop synchronises rx, qualifies the start bit at mid-bit, samples every
// following bit at the centre of its period and deframes LSB-first data with
// optional parity. Each frame is offered downstream on a valid/ready port;
// a frame finishing while the previous one is still unaccepted is dropped
// and reported with a one-clock overrun pulse.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);
    localparam logic          HAS_PAR  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   rx_meta_q, rx_s_q;
    logic                   baud_prev_q;
    logic                   tick;
    logic                   frame_done;
    logic                   accept;

    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;

    assign tick = baud_clk & ~baud_prev_q;

    // Synchronise the asynchronous line (idle high) and remember baud_clk for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            baud_prev_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            baud_prev_q <= baud_clk;
        end
    end

    // FSM state and deframing datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state: everything advances only on an oversample tick
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        frame_done = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            // Line went back high before mid-bit: glitch, not a start bit
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            idx_d   = '0;
                            perr_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_LAST)
                            state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        perr_d  = ((^shift_q) ^ rx_s_q) != ODD;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output side: deliver or drop the finished frame, handle the downstream handshake
    always_comb begin
        accept       = rx_valid_q & rx_ready;
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        busy         = (state_q != S_IDLE);
        if (frame_done && (!rx_valid_q || accept)) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            frame_err_d  = ~rx_s_q;
            parity_err_d = perr_q;
        end else if (frame_done) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end
    end

    // Registered downstream outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: instance 0 is 8N1, instance 1 is 8E1.
// The reference model knows only frame-level timing: a frame whose start bit
// begins right after tick t0 completes on tick t0 + 1 + OS/2 + OS*(bits-1),
// where the line sync and start-detect tick account for the leading 1.
module tb_uart_rx_oversampled;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic baud_clk = 1'b0;
    logic rx_ready = 1'b0;
    logic rx [2];
    logic [7:0] d_data [2];
    logic d_valid [2];
    logic d_fe [2];
    logic d_pe [2];
    logic d_ov [2];
    logic d_busy [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .rx(rx[0]),
        .rx_data(d_data[0]), .rx_valid(d_valid[0]), .rx_ready(rx_ready),
        .frame_err(d_fe[0]), .parity_err(d_pe[0]), .overrun(d_ov[0]), .busy(d_busy[0])
    );

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .rx(rx[1]),
        .rx_data(d_data[1]), .rx_valid(d_valid[1]), .rx_ready(rx_ready),
        .frame_err(d_fe[1]), .parity_err(d_pe[1]), .overrun(d_ov[1]), .busy(d_busy[1])
    );

    // baud_clk toggles every 4 clk; tk is the index of the tick the next posedge carries
    int   nc = 0;
    int   tk = 0;
    logic tick_pend = 1'b0;
    always @(negedge clk) begin
        logic nb;
        nc++;
        nb = ((nc % 8) >= 4);
        tick_pend = nb & ~baud_clk;
        if (tick_pend) tk++;
        baud_clk = nb;
    end

    // frame-level reference model
    logic       m_valid [2] = '{1'b0, 1'b0};
    logic [7:0] m_data  [2] = '{8'h0, 8'h0};
    logic       m_fe    [2] = '{1'b0, 1'b0};
    logic       m_pe    [2] = '{1'b0, 1'b0};
    logic       m_ov    [2] = '{1'b0, 1'b0};
    logic       pend_v  [2] = '{1'b0, 1'b0};
    int         pend_tk [2];
    logic [7:0] pend_data [2];
    logic       pend_fe [2];
    logic       pend_pe [2];

    always @(posedge clk or negedge reset_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_valid[d] = 1'b0; m_data[d] = 8'h0; m_fe[d] = 1'b0;
                m_pe[d] = 1'b0; m_ov[d] = 1'b0; pend_v[d] = 1'b0;
            end else begin
                m_ov[d] = 1'b0;
                if (tick_pend && pend_v[d] && tk == pend_tk[d]) begin
                    pend_v[d] = 1'b0;
                    if (!m_valid[d] || rx_ready) begin
                        m_valid[d] = 1'b1;
                        m_data[d]  = pend_data[d];
                        m_fe[d]    = pend_fe[d];
                        m_pe[d]    = pend_pe[d];
                    end else begin
                        m_ov[d] = 1'b1;
                    end
                end else if (m_valid[d] && rx_ready) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
    end

    // compare process: every cycle, away from the active edge
    int ov_seen [2] = '{0, 0};
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (d_valid[d] !== m_valid[d]) begin
                errors++;
                $display("FAIL valid[%0d] t=%0t: got %b want %b", d, $time, d_valid[d], m_valid[d]);
            end
            if (m_valid[d]) begin
                checks++;
                if ({d_data[d], d_fe[d], d_pe[d]} !== {m_data[d], m_fe[d], m_pe[d]}) begin
                    errors++;
                    $display("FAIL word[%0d] t=%0t: got data=%h fe=%b pe=%b want data=%h fe=%b pe=%b",
                             d, $time, d_data[d], d_fe[d], d_pe[d], m_data[d], m_fe[d], m_pe[d]);
                end
            end
            checks++;
            if (d_ov[d] !== m_ov[d]) begin
                errors++;
                $display("FAIL overrun[%0d] t=%0t: got %b want %b", d, $time, d_ov[d], m_ov[d]);
            end
            if (d_ov[d] === 1'b1) ov_seen[d]++;
        end
    end

    logic rnd_ready = 1'b0;
    always @(negedge clk) begin
        if (rnd_ready) begin
            #1;
            rx_ready = ($urandom_range(0, 15) == 0);
        end
    end

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // returns on the negedge right after the next tick posedge
    task automatic after_tick();
        do begin @(negedge clk); #1; end while (!tick_pend);
        @(negedge clk); #1;
    endtask

    task automatic drive_bit(input int d, input logic v);
        rx[d] = v;
        repeat (OS) after_tick();
    endtask

    // caller must be just after a tick; schedules the model's expectation
    task automatic send_frame(input int d, input logic [7:0] data, input logic stopb, input logic badp);
        int nbits;
        nbits = (d == 1) ? 11 : 10;
        pend_data[d] = data;
        pend_fe[d]   = ~stopb;
        pend_pe[d]   = (d == 1) ? badp : 1'b0;
        pend_tk[d]   = tk + 1 + OS / 2 + OS * (nbits - 1);
        pend_v[d]    = 1'b1;
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
        if (d == 1) drive_bit(d, (^data) ^ badp);
        drive_bit(d, stopb);
        rx[d] = 1'b1;
        if (!stopb) repeat (OS) after_tick();
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(negedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic ready_at(input int t);
        do begin @(negedge clk); #1; end while (!(tick_pend && tk == t));
        rx_ready = 1'b1;
        @(negedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic rand_stream(input int d);
        for (int n = 0; n < 20; n++) begin
            logic [7:0] v;
            logic       sb;
            logic       bp;
            int         gap;
            v   = 8'($urandom);
            sb  = ($urandom_range(0, 7) != 0);
            bp  = (d == 1) && ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            send_frame(d, v, sb, bp);
            repeat (gap * OS) after_tick();
        end
    endtask

    initial begin
        int ov0;
        int target;
        rx[0] = 1'b0;
        rx[1] = 1'b0;

        // reset held with rx low and baud running
        repeat (40) @(negedge clk);
        #1;
        chk("rst_valid0", d_valid[0], 0);
        chk("rst_busy0", d_busy[0], 0);
        chk("rst_busy1", d_busy[1], 0);
        chk("rst_ov0", d_ov[0], 0);
        chk("rst_fe0", d_fe[0], 0);
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) after_tick();
        chk("idle_busy0", d_busy[0], 0);

        // 8N1 0xA5 held until a one-clock ready pulse
        send_frame(0, 8'hA5, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        chk("a5_valid", d_valid[0], 1);
        chk("a5_data", d_data[0], 32'hA5);
        chk("a5_fe", d_fe[0], 0);
        pulse_ready();
        chk("a5_drop", d_valid[0], 0);

        // false start: low for 4 ticks
        after_tick();
        rx[0] = 1'b0;
        repeat (2) after_tick();
        chk("glitch_busy", d_busy[0], 1);
        repeat (2) after_tick();
        rx[0] = 1'b1;
        repeat (5) after_tick();
        chk("glitch_idle", d_busy[0], 0);
        chk("glitch_novalid", d_valid[0], 0);
        send_frame(0, 8'h5A, 1'b1, 1'b0);
        chk("5a_data", d_data[0], 32'h5A);
        pulse_ready();

        // bad stop bit still delivered
        after_tick();
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        chk("3c_valid", d_valid[0], 1);
        chk("3c_data", d_data[0], 32'h3C);
        chk("3c_fe", d_fe[0], 1);
        pulse_ready();

        // back-to-back with nobody accepting: second frame dropped
        after_tick();
        ov0 = ov_seen[0];
        send_frame(0, 8'h11, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1'b1, 1'b0);
        chk("ovr_data", d_data[0], 32'h11);
        chk("ovr_count", ov_seen[0] - ov0, 1);
        pulse_ready();

        // accept on the completion clock: new frame loads, no overrun
        after_tick();
        send_frame(0, 8'h11, 1'b1, 1'b0);
        ov0 = ov_seen[0];
        target = tk + 1 + OS / 2 + OS * 9;
        fork
            send_frame(0, 8'h22, 1'b1, 1'b0);
            ready_at(target);
        join
        chk("simul_data", d_data[0], 32'h22);
        chk("simul_valid", d_valid[0], 1);
        chk("simul_noov", ov_seen[0] - ov0, 0);
        pulse_ready();

        // even parity, 0x07: parity bit 0 is wrong, 1 is right
        after_tick();
        send_frame(1, 8'h07, 1'b1, 1'b1);
        chk("par_bad_pe", d_pe[1], 1);
        chk("par_bad_data", d_data[1], 32'h07);
        pulse_ready();
        after_tick();
        send_frame(1, 8'h07, 1'b1, 1'b0);
        chk("par_ok_pe", d_pe[1], 0);
        chk("par_ok_valid", d_valid[1], 1);

        // reset mid-data while a word is held
        rx[1] = 1'b0;
        repeat (OS) after_tick();
        rx[1] = 1'b1;
        repeat (2 * OS) after_tick();
        rx[1] = 1'b0;
        repeat (8) after_tick();
        chk("mid_busy", d_busy[1], 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", d_valid[1], 0);
        chk("mid_rst_busy", d_busy[1], 0);
        chk("mid_rst_data", d_data[1], 0);
        chk("mid_rst_pe", d_pe[1], 0);
        rx[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;

        // randomized frames on both lines with random backpressure
        repeat (2) after_tick();
        rnd_ready = 1'b1;
        fork
            rand_stream(0);
            rand_stream(1);
        join
        repeat (3 * OS) after_tick();
        rnd_ready = 1'b0;
        @(negedge clk);
        #3;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        rx_ready = 1'b0;
        chk("end_valid0", d_valid[0], 0);
        chk("end_valid1", d_valid[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
